rvv_vd_writeback: RTL and testbench

- Consumer end of the vector ALU lane-result interface.
- Accepts per-lane results with their element indices and valid bits from the lane ALUs.
- Merges each element into a VLEN-bit destination-register image at its SEW position, or at its bit position for mask destinations. Lanes not written keep the old register value.
- Writes completed registers to the vector register file through a ready/valid handshake, advancing through a register group (vd, vd+1, ...) when element indices cross a register boundary.

---
 rtl/rvv_vd_writeback.sv | 162 ++++++++++++++++
 tb/tb_rvv_vd_writeback.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/rvv_vd_writeback.sv
// Vector destination writeback: merges lane ALU results into a VLEN-bit register image and
// writes each completed register to the VRF. Define RVV_WB_TAIL_AGNOSTIC_EN for all-ones tail fill.
module rvv_vd_writeback #(
  parameter int VLEN     = 128,
  parameter int NB_LANES = 1
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       start,
  input  logic [4:0]                 vd_index,
  input  logic [2:0]                 vsew,
  input  logic [16:0]                vl,
  input  logic                       mask_dest,
  input  logic [(64<<NB_LANES)-1:0]  lane_vd,
  input  logic [(17<<NB_LANES)-1:0]  lane_idx,
  input  logic [(1<<NB_LANES)-1:0]   lane_valid,
  input  logic                       alu_done,
  output logic                       wb_ready,
  output logic                       rd_en,
  output logic [4:0]                 rd_index,
  input  logic [VLEN-1:0]            rd_data,
  output logic                       wr_valid,
  output logic [4:0]                 wr_index,
  output logic [VLEN-1:0]            wr_data,
  input  logic                       wr_ready,
  output logic                       busy,
  output logic                       wb_done,
  output logic                       err
);

  localparam int LANES    = 1 << NB_LANES;
  localparam int LOG_VLEN = $clog2(VLEN);

  // Handshakes: a lane beat (and alu_done) is consumed on a clk edge where wb_ready=1;
  // a write is consumed on an edge where wr_valid=1 and wr_ready=1, and wr_* hold until then.
  typedef enum logic [2:0] {IDLE, FETCH1, FETCH2, COLLECT, WRITE, DONE} state_t;
  state_t state_q, state_d;

  logic [4:0]      vd_q, cur_reg, cur_off;
  logic [2:0]      vsew_q, log_sew;
  logic [16:0]     vl_q, epr_m1;
  logic            mask_q, last_q, err_q;
  logic [VLEN-1:0] buf_q, sew_ones, merged, flush_img;
  logic [4:0]      log_epr;
  logic [7:0]      sew_bits;
  logic            full, straddle;

  // Mask destinations behave as 1-bit elements (log_sew=0), so EPR becomes VLEN.
  always_comb begin
    log_sew  = mask_q ? 3'd0 : vsew_q + 3'd3;
    log_epr  = 5'(LOG_VLEN) - {2'b0, log_sew};
    epr_m1   = (17'd1 << log_epr) - 17'd1;
    sew_bits = 8'd1 << log_sew;
    sew_ones = ({{(VLEN-1){1'b0}}, 1'b1} << sew_bits) - {{(VLEN-1){1'b0}}, 1'b1};
    cur_off  = cur_reg - vd_q;
  end

  always_comb begin
    logic [16:0]     idx, slot, pos;
    logic [VLEN-1:0] wmask, wdata;
    merged   = buf_q;
    full     = 1'b0;
    straddle = 1'b0;
    idx      = '0;
    slot     = '0;
    pos      = '0;
    wmask    = '0;
    wdata    = '0;
    for (int l = 0; l < LANES; l++) begin
      idx   = lane_idx[l*17 +: 17];
      slot  = idx & epr_m1;
      pos   = slot << log_sew;
      wmask = sew_ones << pos;
      wdata = (VLEN'(lane_vd[l*64 +: 64]) & sew_ones) << pos;
      if (lane_valid[l]) begin
        if ((idx >> log_epr) == {12'b0, cur_off}) begin
          merged = (merged & ~wmask) | wdata;
          if (slot == epr_m1 && ({1'b0, idx} + 18'd1) < {1'b0, vl_q}) full = 1'b1;
        end else begin
          straddle = 1'b1;
        end
      end
    end
  end

`ifdef RVV_WB_TAIL_AGNOSTIC_EN
  logic [21:0]     tail_base, tail_start;
  logic [VLEN-1:0] tail_mask;
  // Slots at or beyond vl within the current register are tail; fill them with ones.
  always_comb begin
    tail_base  = 22'(cur_off) << log_epr;
    tail_start = ({5'b0, vl_q} > tail_base) ? {5'b0, vl_q} - tail_base : 22'd0;
    tail_mask  = '0;
    if (tail_start <= {5'b0, epr_m1})
      tail_mask = {VLEN{1'b1}} << (tail_start << log_sew);
    flush_img  = merged | tail_mask;
  end
`else
  assign flush_img = merged;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      vd_q    <= '0;
      cur_reg <= '0;
      vsew_q  <= '0;
      vl_q    <= '0;
      mask_q  <= 1'b0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (start) begin
          vd_q    <= vd_index;
          cur_reg <= vd_index;
          vsew_q  <= vsew;
          vl_q    <= vl;
          mask_q  <= mask_dest;
          err_q   <= 1'b0;
        end
        FETCH2: buf_q <= rd_data;
        COLLECT: begin
          buf_q <= alu_done ? flush_img : merged;
          if (straddle) err_q <= 1'b1;
          if (alu_done) last_q <= 1'b1;
          else if (full) last_q <= 1'b0;
        end
        WRITE: if (wr_ready && !last_q) cur_reg <= cur_reg + 5'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = FETCH1;
      FETCH1:  state_d = FETCH2;
      FETCH2:  state_d = COLLECT;
      COLLECT: if (alu_done || full) state_d = WRITE;
      WRITE:   if (wr_ready) state_d = last_q ? DONE : FETCH1;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wb_ready = (state_q == COLLECT);
    rd_en    = (state_q == FETCH1);
    rd_index = (state_q == FETCH1) ? cur_reg : 5'd0;
    wr_valid = (state_q == WRITE);
    wr_index = (state_q == WRITE) ? cur_reg : 5'd0;
    wr_data  = (state_q == WRITE) ? buf_q : '0;
    busy     = (state_q != IDLE);
    wb_done  = (state_q == DONE);
    err      = err_q;
  end

endmodule

// File: tb/tb_rvv_vd_writeback.sv
// Directed scoreboard bench for rvv_vd_writeback (VLEN=128, two lanes).
module tb_rvv_vd_writeback;
  localparam int VLEN = 128;
  localparam int W    = 5 + VLEN;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              start = 1'b0;
  logic [4:0]        vd_index = '0;
  logic [2:0]        vsew = '0;
  logic [16:0]       vl = '0;
  logic              mask_dest = 1'b0;
  logic [127:0]      lane_vd = '0;
  logic [33:0]       lane_idx = '0;
  logic [1:0]        lane_valid = '0;
  logic              alu_done = 1'b0;
  logic              wb_ready, rd_en, wr_valid, busy, wb_done, err;
  logic [4:0]        rd_index, wr_index;
  logic [VLEN-1:0]   rd_data = '0;
  logic [VLEN-1:0]   wr_data;
  logic              wr_ready = 1'b1;

  logic [VLEN-1:0]   regs [32];
  logic [W-1:0]      exp_q[$];
  int                n_vec = 0;
  int                n_err = 0;

  rvv_vd_writeback #(.VLEN(VLEN), .NB_LANES(1)) dut (
    .clk(clk), .resetn(resetn), .start(start), .vd_index(vd_index), .vsew(vsew), .vl(vl),
    .mask_dest(mask_dest), .lane_vd(lane_vd), .lane_idx(lane_idx), .lane_valid(lane_valid),
    .alu_done(alu_done), .wb_ready(wb_ready), .rd_en(rd_en), .rd_index(rd_index),
    .rd_data(rd_data), .wr_valid(wr_valid), .wr_index(wr_index), .wr_data(wr_data),
    .wr_ready(wr_ready), .busy(busy), .wb_done(wb_done), .err(err)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Register file: old value presented the cycle after rd_en
  always @(negedge clk) if (rd_en) rd_data = regs[rd_index];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: pop and compare on every write handshake
  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      #1;
      if (wr_valid && wr_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_write: got v%0d %h expected none", wr_index, wr_data);
        end else begin
          e = exp_q.pop_front();
          check("write", {wr_index, wr_data}, e);
        end
        regs[wr_index] = wr_data;
      end
    end
  end

  // Drivers
  task automatic do_start(input logic [4:0] vd, input logic [2:0] sew, input logic [16:0] len,
                          input logic md);
    @(negedge clk);
    vd_index = vd; vsew = sew; vl = len; mask_dest = md; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic beat(input logic [16:0] i0, input logic [63:0] d0, input logic v0,
                      input logic [16:0] i1, input logic [63:0] d1, input logic v1,
                      input logic done);
    int t;
    t = 0;
    lane_idx = {i1, i0}; lane_vd = {d1, d0}; lane_valid = {v1, v0}; alu_done = done;
    #1;
    while (!wb_ready && t < 100) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (!wb_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL beat_timeout: got wb_ready 0 expected 1");
    end
    @(negedge clk);
    lane_valid = '0; alu_done = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int t;
    t = 0;
    do begin
      @(negedge clk);
      #1;
      t++;
    end while (!wb_done && t < 200);
    check({name, "_wb_done"}, W'(wb_done), W'(1));
    check({name, "_writes_left"}, W'(exp_q.size()), W'(0));
    @(negedge clk);
    #1;
    check({name, "_idle"}, W'({busy, wb_done}), W'(0));
  endtask

  initial begin
    logic [VLEN-1:0] e;
    int t;
    for (int i = 0; i < 32; i++) regs[i] = '0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("reset_ctrl", W'({wb_ready, rd_en, wr_valid, busy, wb_done, err}), W'(0));
    check("reset_idx", W'({rd_index, wr_index}), W'(0));
    check("reset_wr_data", W'(wr_data), W'(0));
    resetn = 1'b1;

    // SEW=8, vl=16: single register v3, byte i = i+1
    regs[3] = {16{8'hAA}};
    for (int i = 0; i < 16; i++) e[i*8 +: 8] = 8'(i + 1);
    exp_q.push_back({5'd3, e});
    do_start(5'd3, 3'd0, 17'd16, 1'b0);
    for (int k = 0; k < 8; k++)
      beat(17'(2*k), 64'(2*k + 1), 1'b1, 17'(2*k + 1), 64'(2*k + 2), 1'b1, k == 7);
    wait_done("sew8");

    // SEW=32, vl=6 across v4/v5, first write stalled 5 cycles with the next beat held
    regs[4] = {4{32'h11111111}};
    regs[5] = {4{32'h11111111}};
    exp_q.push_back({5'd4, 32'h103, 32'h102, 32'h101, 32'h100});
`ifdef RVV_WB_TAIL_AGNOSTIC_EN
    exp_q.push_back({5'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h105, 32'h104});
`else
    exp_q.push_back({5'd5, 32'h11111111, 32'h11111111, 32'h105, 32'h104});
`endif
    wr_ready = 1'b0;
    do_start(5'd4, 3'd2, 17'd6, 1'b0);
    fork
      begin
        beat(17'd0, 64'h100, 1'b1, 17'd1, 64'h101, 1'b1, 1'b0);
        beat(17'd2, 64'h102, 1'b1, 17'd3, 64'h103, 1'b1, 1'b0);
        beat(17'd4, 64'h104, 1'b1, 17'd5, 64'h105, 1'b1, 1'b1);
      end
      begin
        t = 0;
        do begin
          @(negedge clk);
          #1;
          t++;
        end while (!wr_valid && t < 100);
        for (int k = 0; k < 5; k++) begin
          check("stall_wr", {wr_valid, wb_ready, wr_index, wr_data},
                {1'b1, 1'b0, 5'd4, 32'h103, 32'h102, 32'h101, 32'h100});
          @(negedge clk);
          #1;
        end
        @(negedge clk);
        wr_ready = 1'b1;
      end
    join
    wait_done("sew32");

    // SEW=64, vl=4 on v10/v11 with one lane straddling back into v10
    regs[10] = '1;
    regs[11] = '1;
    exp_q.push_back({5'd10, 64'hA1, 64'hA0});
    exp_q.push_back({5'd11, 64'hA3, 64'hA2});
    do_start(5'd10, 3'd3, 17'd4, 1'b0);
    beat(17'd0, 64'hA0, 1'b1, 17'd1, 64'hA1, 1'b1, 1'b0);
    beat(17'd2, 64'hA2, 1'b1, 17'd0, 64'hBAD, 1'b1, 1'b0);
    beat(17'd3, 64'hA3, 1'b1, 17'd0, 64'h0, 1'b0, 1'b1);
    wait_done("straddle");
    check("err_sticky", W'(err), W'(1));

    // Mask destination, vl=10, bit0 alternating from 0; start clears err
    regs[7] = '1;
    e = '1;
    e[9:0] = 10'b1010101010;
    exp_q.push_back({5'd7, e});
    do_start(5'd7, 3'd0, 17'd10, 1'b1);
    #1;
    check("err_cleared", W'(err), W'(0));
    for (int k = 0; k < 5; k++)
      beat(17'(2*k), 64'hFFFE, 1'b1, 17'(2*k + 1), 64'h3, 1'b1, k == 4);
    wait_done("mask");

    // Reset during COLLECT, then vl=0 flush on a fresh start
    do_start(5'd8, 3'd0, 17'd16, 1'b0);
    beat(17'd0, 64'h5A, 1'b1, 17'd1, 64'h5B, 1'b1, 1'b0);
    resetn = 1'b0;
    @(negedge clk);
    #1;
    check("reset_collect", W'({busy, wr_valid, wb_ready, err}), W'(0));
    resetn = 1'b1;
    regs[9] = 128'h0123456789ABCDEF_FEDCBA9876543210;
`ifdef RVV_WB_TAIL_AGNOSTIC_EN
    exp_q.push_back({5'd9, {VLEN{1'b1}}});
`else
    exp_q.push_back({5'd9, 128'h0123456789ABCDEF_FEDCBA9876543210});
`endif
    do_start(5'd9, 3'd2, 17'd0, 1'b0);
    beat(17'd0, 64'h0, 1'b0, 17'd0, 64'h0, 1'b0, 1'b1);
    wait_done("vl0");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
